fetch_sequencer: RTL

//  Control FSM that sequences the program counter and instruction-memory fetch of the 8-bit core.
//  - Issues one imem read per instruction and buffers the returned word.
//  - Presents the word to decode with a valid/ready handshake.
//  - Waits for branch resolution, then commands the PC register to advance, take the branch offset, or hold on halt.
//  - Sits between the PC register, the instruction memory and decode.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_perf_cnt.sv | 46 ++++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch sequencer of the 8-bit core:
//   - default PC / instruction word widths
//   - fetch_state_t, the sequencer FSM state encoding
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_ISSUE   = 3'd3,
    S_RESOLVE = 3'd4,
    S_HALTED  = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// -----------------------------------------------------------------------------
// fetch_perf_cnt
// Two 16-bit saturating event counters for the fetch sequencer.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset, clears both counters
//   instr_inc_i    count one issued instruction this cycle
//   stall_inc_i    count one stall (WAIT/RESOLVE) cycle
//   perf_instr_o   issued-instruction count, saturates at 16'hFFFF
//   perf_stall_o   stall-cycle count, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module fetch_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_inc_i,
  input  logic        stall_inc_i,
  output logic [15:0] perf_instr_o,
  output logic [15:0] perf_stall_o
);

  logic [15:0] cnt_instr_q, cnt_instr_d;
  logic [15:0] cnt_stall_q, cnt_stall_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  assign cnt_instr_d = sat_inc(cnt_instr_q, instr_inc_i);
  assign cnt_stall_d = sat_inc(cnt_stall_q, stall_inc_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_instr_q <= 16'h0000;
      cnt_stall_q <= 16'h0000;
    end else begin
      cnt_instr_q <= cnt_instr_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  assign perf_instr_o = cnt_instr_q;
  assign perf_stall_o = cnt_stall_q;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Control FSM sequencing PC update and instruction fetch for the 8-bit core.
// Issues one imem read per instruction, buffers the returned word, hands it
// to decode with valid/ready, then commands the PC register (inc / take /
// hold) once decode and branch resolution allow.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_instr_o / perf_stall_o.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   start_i                  begin/resume fetching (IDLE and HALTED only)
//   pc_i                     current PC from the PC register
//   imem_req_o, imem_addr_o  one-cycle read strobe and address
//   imem_rdata_i/_rvalid_i   read return
//   instr_o, instr_valid_o   buffered instruction to decode
//   instr_ready_i            decode accepts instr
//   is_branch_i, is_halt_i   decode classification of presented instr
//   br_resolved_i/_taken_i   branch outcome
//   pc_inc_o, pc_take_o      one-cycle PC commands (Mealy)
//   halted_o                 core halted
//   perf_instr_o/_stall_o    (FETCH_PERF_CNT_EN only) event counters
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               imem_rvalid_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               is_branch_i,
  input  logic               is_halt_i,
  input  logic               br_resolved_i,
  input  logic               br_taken_i,
  output logic               pc_inc_o,
  output logic               pc_take_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        perf_instr_o,
  output logic [15:0]        perf_stall_o,
`endif
  output logic               halted_o
);

  fetch_state_t        state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                req_q, valid_q, halted_q;
  logic                pc_inc, pc_take;

  // Next state, instruction capture and Mealy PC commands.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_inc  = 1'b0;
    pc_take = 1'b0;
    unique case (state_q)
      S_IDLE:    if (start_i) state_d = S_FETCH;
      S_FETCH:   state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_ready_i) begin
          // Halt wins over branch; a halt leaves the PC on the halt word.
          if (is_halt_i)        state_d = S_HALTED;
          else if (is_branch_i) state_d = S_RESOLVE;
          else begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_RESOLVE: begin
        if (br_resolved_i) begin
          pc_take = br_taken_i;
          pc_inc  = ~br_taken_i;
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        // Resuming steps past the halt instruction.
        if (start_i) begin
          pc_inc  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      req_q    <= (state_d == S_FETCH);
      valid_q  <= (state_d == S_ISSUE);
      halted_q <= (state_d == S_HALTED);
    end
  end

  // The PC register updates on the edge entering FETCH, so the address is
  // taken live from pc_i rather than registered.
  assign imem_req_o    = req_q;
  assign imem_addr_o   = req_q ? pc_i : '0;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = halted_q;
  assign pc_inc_o      = pc_inc;
  assign pc_take_o     = pc_take;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .instr_inc_i  ((state_q == S_ISSUE) && instr_ready_i),
    .stall_inc_i  ((state_q == S_WAIT) || (state_q == S_RESOLVE)),
    .perf_instr_o (perf_instr_o),
    .perf_stall_o (perf_stall_o)
  );
`endif

endmodule
